// File: rtl/frame_tx_packer.sv
// Transmit framer: wraps each frame as sync0, sync1, pixel bytes and an XOR checksum, through one output byte slot.
// Optional macro FRAME_TX_SATURATE_EN: pixel byte saturates to 8'hFF when data_i has bits set above the window.
module frame_tx_packer #(
    parameter int         in_width_p     = 15,
    parameter int         shift_p        = 3,
    parameter int         linewidth_px_p = 161,
    parameter int         lines_p        = 120,
    parameter logic [7:0] sync0_p        = 8'hA5,
    parameter logic [7:0] sync1_p        = 8'h5A
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [in_width_p-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [7:0]            data_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);
    localparam int COL_W = (linewidth_px_p > 1) ? $clog2(linewidth_px_p) : 1;
    localparam int ROW_W = (lines_p > 1) ? $clog2(lines_p) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(linewidth_px_p - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(lines_p - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC1 = 3'd1,
        ST_PIX   = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [7:0] window_byte(input logic [in_width_p-1:0] d);
`ifdef FRAME_TX_SATURATE_EN
        if ((d >> (shift_p + 8)) != {in_width_p{1'b0}}) begin
            return 8'hFF;
        end else begin
            return 8'(d >> shift_p);
        end
`else
        return 8'(d >> shift_p);
`endif
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [7:0]       csum_r;
    logic             valid_r;
    logic [7:0]       data_r;

    logic             slot_free_s;
    logic             load_s;
    logic [7:0]       load_byte_s;
    logic [7:0]       pix_byte_s;
    logic             pix_hs_s;
    logic             pix_last_s;
    logic             csum_clr_s;
    logic             ready_s;
    logic             frame_done_s;

    assign slot_free_s = !valid_r || ready_i;
    assign pix_byte_s  = window_byte(data_i);
    assign pix_last_s  = (col_r == COL_LAST) && (row_r == ROW_LAST);

    // Next-state, slot load selection and pixel-side handshake.
    always_comb begin
        state_nxt_s  = state_r;
        load_s       = 1'b0;
        load_byte_s  = 8'h00;
        ready_s      = 1'b0;
        pix_hs_s     = 1'b0;
        csum_clr_s   = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid_i && slot_free_s) begin
                    load_s      = 1'b1;
                    load_byte_s = sync0_p;
                    state_nxt_s = ST_SYNC1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SYNC1: begin
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    load_byte_s = sync1_p;
                    csum_clr_s  = 1'b1;
                    state_nxt_s = ST_PIX;
                end else begin
                    state_nxt_s = ST_SYNC1;
                end
            end
            ST_PIX: begin
                // ready depends only on the slot, never on valid_i
                ready_s = slot_free_s;
                if (valid_i && slot_free_s) begin
                    pix_hs_s    = 1'b1;
                    load_s      = 1'b1;
                    load_byte_s = pix_byte_s;
                    if (pix_last_s) begin
                        state_nxt_s = ST_CSUM;
                    end else begin
                        state_nxt_s = ST_PIX;
                    end
                end else begin
                    state_nxt_s = ST_PIX;
                end
            end
            ST_CSUM: begin
                if (slot_free_s) begin
                    load_s      = 1'b1;
                    load_byte_s = csum_r;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CSUM;
                end
            end
            ST_DONE: begin
                if (valid_r && ready_i) begin
                    frame_done_s = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s  = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frame state register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pixel position counters; advance only on pixel handshakes.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (pix_hs_s) begin
            if (col_r == COL_LAST) begin
                col_r <= {COL_W{1'b0}};
                if (row_r == ROW_LAST) begin
                    row_r <= {ROW_W{1'b0}};
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Running XOR of pixel bytes; cleared as sync1 is loaded.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            csum_r <= 8'h00;
        end else if (csum_clr_s) begin
            csum_r <= 8'h00;
        end else if (pix_hs_s) begin
            csum_r <= csum_r ^ pix_byte_s;
        end
    end

    // Output byte slot: holds while stalled, reloads or empties when free.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_r <= 1'b0;
            data_r  <= 8'h00;
        end else if (slot_free_s) begin
            valid_r <= load_s;
            if (load_s) begin
                data_r <= load_byte_s;
            end
        end
    end

    assign ready_o      = ready_s;
    assign valid_o      = valid_r;
    assign data_o       = data_r;
    assign busy_o       = (state_r != ST_IDLE);
    assign frame_done_o = frame_done_s;

endmodule

// File: tb/tb_frame_tx_packer.sv
// Self-checking bench for frame_tx_packer (4x2 frame) against a byte-level frame model.
module tb_frame_tx_packer;
    localparam int NPIX = 8;
    localparam int FLEN = NPIX + 3;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [14:0] data_i = 15'h0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [7:0]  data_o;
    logic        busy_o;
    logic        frame_done_o;

    frame_tx_packer #(
        .in_width_p(15), .shift_p(3), .linewidth_px_p(4), .lines_p(2),
        .sync0_p(8'hA5), .sync1_p(8'h5A)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;

    logic [14:0] src_q[$];
    logic [7:0]  out_q[$];
    int          out_cyc_q[$];
    logic [7:0]  exp_q[$];
    int          acc_at_done_q[$];
    int          done_idx_q[$];
    logic        busy_after_done_q[$];
    int acc_cnt = 0, done_cnt = 0, stall_viol = 0, done_viol = 0, rdy_idle_viol = 0;
    logic prev_stall = 1'b0, prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [14:0] frame_px [NPIX];

    function automatic logic [7:0] model_byte(input logic [14:0] d);
        int v;
        v = int'(d);
`ifdef FRAME_TX_SATURATE_EN
        if (v >= 2048) return 8'hFF;
`endif
        return 8'((v / 8) % 256);
    endfunction

    // Source, sink and observation process
    initial begin : bfm
        bit hs;
        forever begin
            @(negedge clk_i);
            cyc++;
            hs = (valid_i && ready_o);
            if (hs) acc_cnt++;
            if (ready_o && !busy_o) rdy_idle_viol++;
            if (prev_stall && (valid_o !== 1'b1 || data_o !== prev_data)) stall_viol++;
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
            if (prev_done) busy_after_done_q.push_back(busy_o);
            prev_done = frame_done_o;
            if (valid_o && ready_i) begin
                out_q.push_back(data_o);
                out_cyc_q.push_back(cyc);
            end
            if (frame_done_o) begin
                done_cnt++;
                acc_at_done_q.push_back(acc_cnt);
                done_idx_q.push_back(out_q.size() - 1);
                if (!(valid_o && ready_i)) done_viol++;
            end
            @(posedge clk_i);
            #1;
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            valid_i = (src_q.size() > 0);
            data_i  = (src_q.size() > 0) ? src_q[0] : 15'h0;
            case (ready_mode)
                0: ready_i = 1'b1;
                1: ready_i = !ready_i;
                default: ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic clear_log();
        out_q.delete(); out_cyc_q.delete(); exp_q.delete();
        acc_at_done_q.delete(); done_idx_q.delete(); busy_after_done_q.delete();
        acc_cnt = 0; done_cnt = 0; stall_viol = 0; done_viol = 0; rdy_idle_viol = 0;
    endtask

    task automatic queue_frame();
        logic [7:0] x;
        x = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < NPIX; i++) begin
            src_q.push_back(frame_px[i]);
            exp_q.push_back(model_byte(frame_px[i]));
            x = x ^ model_byte(frame_px[i]);
        end
        exp_q.push_back(x);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (done_cnt < n && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        checks++;
        if (done_cnt < n) begin
            errors++;
            $display("FAIL wait_frames: frames done %0d, required %0d within %0d cycles", done_cnt, n, budget);
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done_o); end
        #2 reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_basic();
        logic [7:0] got;
        ready_mode = 0;
        clear_log();
        for (int i = 0; i < NPIX; i++) frame_px[i] = 15'(((i + 1) << 3) | $urandom_range(0, 7));
        queue_frame();
        wait_frames(1, 300);
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len: got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL basic_byte[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (done_idx_q.size() != 1 || done_idx_q[0] != FLEN - 1) begin errors++; $display("FAIL basic_done_on_csum: got %0d pulses want pulse at byte %0d", done_idx_q.size(), FLEN - 1); end
        checks++; if (busy_after_done_q.size() != 1 || busy_after_done_q[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %0d samples want one low sample", busy_after_done_q.size()); end
        checks++; if (acc_at_done_q.size() != 1 || acc_at_done_q[0] != NPIX) begin errors++; $display("FAIL basic_pixels: got %0d want %0d", acc_cnt, NPIX); end
        checks++; if (done_viol != 0) begin errors++; $display("FAIL basic_done_hs: got %0d pulses off handshake want 0", done_viol); end
    endtask

    task automatic test_backpressure();
        logic [7:0] got;
        ready_mode = 1;
        clear_log();
        for (int i = 0; i < NPIX; i++) frame_px[i] = 15'(((i + 1) << 3) | $urandom_range(0, 7));
        queue_frame();
        wait_frames(1, 400);
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_len: got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL bp_byte[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol); end
        checks++; if (acc_cnt != NPIX) begin errors++; $display("FAIL bp_pixels: got %0d want %0d", acc_cnt, NPIX); end
    endtask

    task automatic test_window();
        logic [7:0] got;
        logic [7:0] want_4008;
`ifdef FRAME_TX_SATURATE_EN
        want_4008 = 8'hFF;
`else
        want_4008 = 8'h01;
`endif
        ready_mode = 2;
        clear_log();
        frame_px[0] = 15'h07F8;
        frame_px[1] = 15'h4008;
        for (int i = 2; i < NPIX; i++) frame_px[i] = 15'($urandom);
        queue_frame();
        wait_frames(1, 600);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL win_byte[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        got = (out_q.size() > 2) ? out_q[2] : 8'hxx;
        checks++; if (got !== 8'hFF) begin errors++; $display("FAIL win_07F8: got %h want FF", got); end
        got = (out_q.size() > 3) ? out_q[3] : 8'hxx;
        checks++; if (got !== want_4008) begin errors++; $display("FAIL win_4008: got %h want %h", got, want_4008); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL win_stable: got %0d unstable stalls want 0", stall_viol); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        int gap;
        ready_mode = 0;
        clear_log();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NPIX; i++) frame_px[i] = 15'($urandom);
            queue_frame();
        end
        wait_frames(2, 400);
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len: got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        gap = (out_cyc_q.size() > FLEN) ? out_cyc_q[FLEN] - out_cyc_q[FLEN-1] : 999;
        checks++; if (gap > 2) begin errors++; $display("FAIL b2b_gap: got %0d cycles want <= 2", gap); end
        checks++; if (acc_at_done_q.size() != 2 || acc_at_done_q[0] != NPIX || acc_at_done_q[1] != 2 * NPIX) begin
            errors++; $display("FAIL b2b_pixels_at_done: got %0d frames, %0d pixels want 2 frames, %0d pixels", acc_at_done_q.size(), acc_cnt, 2 * NPIX);
        end
        checks++; if (rdy_idle_viol != 0) begin errors++; $display("FAIL b2b_ready_idle: got %0d want 0", rdy_idle_viol); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        int k;
        ready_mode = 0;
        clear_log();
        for (int i = 0; i < NPIX; i++) frame_px[i] = 15'($urandom);
        queue_frame();
        k = 0;
        while (acc_cnt < 3 && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        checks++; if (acc_cnt < 3) begin errors++; $display("FAIL rst_mid_wait: got %0d pixels want 3", acc_cnt); end
        @(posedge clk_i);
        #3;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b want 1", busy_o); end
        reset_i = 1'b0;
        prev_stall = 1'b0;
        src_q.delete();
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
        repeat (2) @(negedge clk_i);
        #2 reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        clear_log();
        for (int i = 0; i < NPIX; i++) frame_px[i] = 15'($urandom);
        queue_frame();
        wait_frames(1, 300);
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_mid_len: got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hxx;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL rst_mid_byte[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_window();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
